// File: rtl/synapse_current_driver.sv
// Synapse current driver: buffers weighted spike events in a small FIFO and folds them into an
// exponentially decaying, saturating accumulator whose biased value is the registered neuron input current code.
module synapse_current_driver #(
    parameter int W_WIDTH     = 8,
    parameter int W_SHIFT     = 8,
    parameter int I_WIDTH     = 24,
    parameter int DECAY_SHIFT = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int BIAS        = 0,
    parameter int I_EXP       = -48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      spike_valid,
    input  logic signed [W_WIDTH-1:0] spike_weight,
    output logic                      spike_ready,
    output logic signed [I_WIDTH-1:0] I_out,
    output logic                      busy,
    output logic [7:0]                sat_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ADD_W = W_WIDTH + W_SHIFT;
    localparam int NW    = ((I_WIDTH > ADD_W) ? I_WIDTH : ADD_W) + 2;

    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic signed [NW-1:0] I_MAX    = {{(NW-I_WIDTH+1){1'b0}}, {(I_WIDTH-1){1'b1}}};
    localparam logic signed [NW-1:0] I_MIN    = ~I_MAX;
    localparam logic signed [NW-1:0] BIAS_EXT = NW'(BIAS);

    function automatic logic signed [I_WIDTH-1:0] sat_i(input logic signed [NW-1:0] v);
        if (v > I_MAX) return I_MAX[I_WIDTH-1:0];
        if (v < I_MIN) return I_MIN[I_WIDTH-1:0];
        return v[I_WIDTH-1:0];
    endfunction

    function automatic logic clips(input logic signed [NW-1:0] v);
        return (v > I_MAX) || (v < I_MIN);
    endfunction

    localparam logic signed [I_WIDTH-1:0] I_RST = sat_i(BIAS_EXT);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (I_EXP >= 0) begin : g_bad_exp
        $error("I_EXP must be negative: the current LSB is a fraction of an ampere");
    end

    logic signed [W_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q, count_d;
    logic signed [I_WIDTH-1:0] acc_q, acc_d;
    logic signed [I_WIDTH-1:0] i_out_q, i_out_d;
    logic [7:0]                sat_cnt_q, sat_cnt_d;

    logic                      full, empty, push, pop;
    logic signed [W_WIDTH-1:0] pop_weight;
    logic signed [NW-1:0]      acc_ext, dec, add, sum, out_sum;
    logic                      acc_clip, out_clip;

    // Ready looks only at the registered occupancy, so a full FIFO refuses even while popping.
    always_comb begin
        full        = (count_q == FULL_CNT);
        empty       = (count_q == '0);
        spike_ready = !full && !rst;
        push        = spike_valid && spike_ready;
        pop         = en && !empty;
        pop_weight  = mem_q[rd_ptr_q];
    end

    // NOTE: every always_comb output gets a value before any branch; otherwise a path that skips
    // the assignment would infer a latch.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        acc_ext = NW'(acc_q);
        dec     = acc_ext >>> DECAY_SHIFT;
        // Floor shift stalls small positive values above zero; force a unit step so they drain.
        if (dec == '0 && !acc_q[I_WIDTH-1] && acc_q != '0) dec = NW'(1);
        add      = pop ? (NW'(pop_weight) <<< W_SHIFT) : '0;
        sum      = acc_ext - dec + add;
        acc_d    = sat_i(sum);
        acc_clip = clips(sum);
        out_sum  = NW'(acc_d) + BIAS_EXT;
        i_out_d  = sat_i(out_sum);
        out_clip = clips(out_sum);
        sat_cnt_d = sat_cnt_q;
        if ((acc_clip || out_clip) && sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge
    // values; blocking assignments here would create order-dependent races between blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            i_out_q   <= I_RST;
            sat_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (en) begin
                acc_q     <= acc_d;
                i_out_q   <= i_out_d;
                sat_cnt_q <= sat_cnt_d;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and pointers define which
    // entries are valid, and leaving the array reset-free lets it map to plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= spike_weight;
    end

    assign I_out   = i_out_q;
    assign sat_cnt = sat_cnt_q;
    assign busy    = !empty || (acc_q != '0);

endmodule

// File: doc/synapse_current_driver.md
Name: synapse_current_driver

Overview:
- Produces the input current that drives a neuron block's I_in from a stream of weighted spike events.
- Spike events enter through a valid/ready handshake and are buffered in a small FIFO.
- Events are popped at most one per cycle into an exponentially decaying signed accumulator, which is offset by a constant bias.
- The result is a registered signed fixed-point current code with LSB = 2^I_EXP A, which feeds the svreal/msdsl neuron input through a fixed-to-real conversion wrapper.

Parameters:
- W_WIDTH, 8: signed spike weight width.
- W_SHIFT, 8: left shift applied to a weight before accumulation.
- I_WIDTH, 24: signed accumulator and output width.
- DECAY_SHIFT, 4: per-cycle decay is acc >>> DECAY_SHIFT (tau ≈ 2^DECAY_SHIFT cycles).
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2).
- BIAS, 0: signed constant current code added to the output.
- I_EXP, -48: LSB exponent of I_out in amperes (informational; used by the wrapper).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  update enable; when low, no pop and no decay (accumulator and I_out hold).
- spike_valid  in  1  event present.
- spike_weight  in  W_WIDTH  signed event weight.
- spike_ready  out  1  FIFO can accept.
- I_out  out  I_WIDTH  signed current code, registered.
- busy  out  1  FIFO non-empty or acc != 0.
- sat_cnt  out  8  saturating count of saturation events.

Behaviour:
- Reset values (rst high at an edge):
  - FIFO emptied; pending events discarded.
  - acc = 0.
  - I_out = sat(BIAS).
  - sat_cnt = 0.
  - spike_ready = 0 while rst is high, then !full.
  - busy = 0.
- Handshake and FIFO:
  - Push occurs when spike_valid && spike_ready at an edge.
  - spike_ready = !full && !rst. It depends only on FIFO state, never on a same-cycle pop, so a full FIFO does not accept even when popping.
  - Weight must be held stable while valid && !ready.
  - Pointers wrap modulo FIFO_DEPTH. A count register distinguishes full from empty.
- Pop: when en && FIFO non-empty at the start of the cycle, pop one entry that cycle. An entry pushed at edge k is poppable no earlier than the cycle after edge k.
- Decay step, computed on acc:
  - d = acc >>> DECAY_SHIFT (arithmetic shift).
  - If d == 0 and acc > 0, d = 1. This guarantees positive values reach 0; negative values reach 0 naturally because floor gives -1.
- Accumulator update, applied only when en = 1:
  - add = pop ? (sext(weight) << W_SHIFT) : 0.
  - next = acc - d + add, computed at I_WIDTH+2 bits.
  - Saturate next to [-2^(I_WIDTH-1), 2^(I_WIDTH-1)-1] and assign to acc.
- Output update, at the same edge as acc: I_out = sat(acc_new + BIAS).
- Latency: handshake at edge k with FIFO empty and en=1 → weight is visible in I_out after edge k+1.
- sat_cnt: increments by 1 at each edge where either saturation (acc or I_out) clips. It sticks at 255.
- en = 0: acc, I_out, and sat_cnt hold. FIFO still accepts until full. busy still reflects state.
- Simultaneous push and pop in the same cycle: count is unchanged and both operations are performed.
- Reset mid-operation: takes priority over all events. The same-edge handshake is dropped and the weight is not applied.
- No X propagation: spike_weight is ignored unless spike_valid is high.

Test Plan (default parameters unless stated):
1. Reset: hold rst 3 cycles → I_out=0, sat_cnt=0, busy=0, spike_ready=0 during reset and 1 on the first cycle after.
2. Single event: weight=10 accepted at edge k, en=1 → I_out=2560 after edge k+1, then 2400, 2250 on following edges. busy=1 until acc reaches 0.
3. Backpressure: en=0, present 6 back-to-back events → first 4 accepted, spike_ready=0 from the 5th, I_out unchanged. Raise en → one pop per cycle. spike_ready returns to 1 the cycle after the first pop.
4. Saturation (I_WIDTH=16): two weight-127 events on consecutive cycles → I_out=32512, then 62992 clipped to 32767, sat_cnt=1.
5. Negative and tail: weight=-128 → I_out=-32768, then decays monotonically toward 0. Force acc=5 path: 5→4→3→2→1→0, then busy=0.
6. Reset mid-burst (BIAS=100): 3 events queued with en=0, pulse rst one cycle → I_out=100, FIFO empty, and a later en=1 produces no weight contribution.
